wb_stage: RTL and testbench

//  Write-back stage. Accepts retired MEM-stage bundles over a valid/allowin handshake.

---
 rtl/cpuDefine.sv | 55 +++++
 rtl/load_extend.sv | 37 +++
 rtl/wb_stage.sv | 157 +++++++++++++++
 tb/tb_wb_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpuDefine.sv
// Shared CPU types for the write-back stage: register/data widths, select
// encodings, WB state encoding and the MEM->WB bundle.
package cpuDefine;

  localparam int DATA_WIDTH = 32;
  localparam int GR_WIDTH   = 5;
  localparam int PC_WIDTH   = 32;

  typedef logic [GR_WIDTH-1:0]   Gr;
  typedef logic [DATA_WIDTH-1:0] DType;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_PC4  = 2'd2,
    RES_CSR  = 2'd3
  } res_sel_e;

  typedef enum logic [1:0] {
    WB_EMPTY  = 2'd0,
    WB_WAIT   = 2'd1,
    WB_COMMIT = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    Gr                   rd;
    logic                we;
    res_sel_e            res_sel;
    ld_type_e            ld_type;
    logic [1:0]          addr_lo;
    DType                alu_res;
    DType                csr_rdata;
  } ms_to_ws_bus_t;

  // Result for every source that is known at accept time (loads resolve later).
  function automatic DType wb_result(input ms_to_ws_bus_t b);
    DType r;
    case (b.res_sel)
      RES_PC4: r = DType'(b.pc + PC_WIDTH'(4));
      RES_CSR: r = b.csr_rdata;
      default: r = b.alu_res;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension; purely combinational.
// Selects the byte/half lane addressed by addr_lo; word loads ignore addr_lo.
module load_extend
  import cpuDefine::*;
(
  input  ld_type_e   ld_type_i,
  input  logic [1:0] addr_lo_i,
  input  DType       rdata_i,
  output DType       data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      2'd3:    byte_lane = rdata_i[31:24];
      default: byte_lane = rdata_i[7:0];
    endcase
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (ld_type_i)
      LD_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
      LD_BU:   data_o = {24'd0, byte_lane};
      LD_H:    data_o = {{16{half_lane[15]}}, half_lane};
      LD_HU:   data_o = {16'd0, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits MEM bundles to the register file one cycle after
// accept, or one cycle after the data response for loads; exports load-use info.
module wb_stage
  import cpuDefine::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 5,
  parameter int PC_W      = 32
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 ms_valid,
  output logic                 ws_allowin,
  input  logic [PC_W-1:0]      ms_pc,
  input  logic [RF_ADDR_W-1:0] ms_rd,
  input  logic                 ms_we,
  input  logic [1:0]           ms_res_sel,
  input  logic [2:0]           ms_ld_type,
  input  logic [1:0]           ms_addr_lo,
  input  logic [DATA_W-1:0]    ms_alu_res,
  input  logic [DATA_W-1:0]    ms_csr_rdata,
  input  logic                 data_rvalid,
  input  logic [DATA_W-1:0]    data_rdata,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 ws_pend_we,
  output logic [RF_ADDR_W-1:0] ws_pend_rd,
  output logic [PC_W-1:0]      debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [RF_ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0]    debug_wb_rf_wdata
);

  wb_state_e     state_q, state_d;
  ms_to_ws_bus_t ms_bus;
  logic          accept;

  // Fields of an outstanding load needed once the data response arrives.
  logic            pend_we_q, pend_we_d;
  Gr               pend_rd_q, pend_rd_d;
  ld_type_e        pend_ld_q, pend_ld_d;
  logic [1:0]      pend_lo_q, pend_lo_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;

  logic            rf_we_q, rf_we_d;
  Gr               rf_waddr_q, rf_waddr_d;
  DType            rf_wdata_q, rf_wdata_d;
  logic [PC_W-1:0] wb_pc_q, wb_pc_d;

  DType ld_ext;

  always_comb begin
    ms_bus.pc        = ms_pc;
    ms_bus.rd        = ms_rd;
    ms_bus.we        = ms_we;
    ms_bus.res_sel   = res_sel_e'(ms_res_sel);
    ms_bus.ld_type   = ld_type_e'(ms_ld_type);
    ms_bus.addr_lo   = ms_addr_lo;
    ms_bus.alu_res   = ms_alu_res;
    ms_bus.csr_rdata = ms_csr_rdata;
  end

  assign ws_allowin = (state_q != WB_WAIT);
  assign accept     = ms_valid && ws_allowin;

  load_extend u_load_extend (
    .ld_type_i (pend_ld_q),
    .addr_lo_i (pend_lo_q),
    .rdata_i   (data_rdata),
    .data_o    (ld_ext)
  );

  always_comb begin
    state_d    = state_q;
    pend_we_d  = pend_we_q;
    pend_rd_d  = pend_rd_q;
    pend_ld_d  = pend_ld_q;
    pend_lo_d  = pend_lo_q;
    pend_pc_d  = pend_pc_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_pc_d    = wb_pc_q;

    case (state_q)
      WB_WAIT: begin
        // A response is only meaningful here; anywhere else it is dropped.
        if (data_rvalid) begin
          state_d    = WB_COMMIT;
          rf_we_d    = pend_we_q && (pend_rd_q != '0);
          rf_waddr_d = pend_rd_q;
          rf_wdata_d = ld_ext;
          wb_pc_d    = pend_pc_q;
        end
      end
      default: begin
        if (accept) begin
          if (ms_bus.res_sel == RES_LOAD) begin
            state_d   = WB_WAIT;
            pend_we_d = ms_bus.we;
            pend_rd_d = ms_bus.rd;
            pend_ld_d = ms_bus.ld_type;
            pend_lo_d = ms_bus.addr_lo;
            pend_pc_d = ms_bus.pc;
          end else begin
            state_d    = WB_COMMIT;
            rf_we_d    = ms_bus.we && (ms_bus.rd != '0);
            rf_waddr_d = ms_bus.rd;
            rf_wdata_d = wb_result(ms_bus);
            wb_pc_d    = ms_bus.pc;
          end
        end else begin
          state_d = WB_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= WB_EMPTY;
      pend_we_q  <= 1'b0;
      pend_rd_q  <= '0;
      pend_ld_q  <= LD_B;
      pend_lo_q  <= '0;
      pend_pc_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_we_q  <= pend_we_d;
      pend_rd_q  <= pend_rd_d;
      pend_ld_q  <= pend_ld_d;
      pend_lo_q  <= pend_lo_d;
      pend_pc_q  <= pend_pc_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_pc_q    <= wb_pc_d;
    end
  end

  assign ws_pend_we = (state_q == WB_WAIT) && pend_we_q && (pend_rd_q != '0);
  assign ws_pend_rd = pend_rd_q;

  assign rf_we             = rf_we_q;
  assign rf_waddr          = rf_waddr_q;
  assign rf_wdata          = rf_wdata_q;
  assign debug_wb_pc       = wb_pc_q;
  assign debug_wb_rf_we    = {4{rf_we_q}};
  assign debug_wb_rf_wnum  = rf_waddr_q;
  assign debug_wb_rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios then randomized bundles, each commit
// checked against an arithmetic model of the write-back result rules.
module tb_wb_stage;

  logic        aclk = 1'b0;
  logic        areset;
  logic        ms_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [4:0]  ms_rd;
  logic        ms_we;
  logic [1:0]  ms_res_sel;
  logic [2:0]  ms_ld_type;
  logic [1:0]  ms_addr_lo;
  logic [31:0] ms_alu_res;
  logic [31:0] ms_csr_rdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_pend_we;
  logic [4:0]  ws_pend_rd;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_waddr;
  logic [31:0] last_wdata;
  logic [31:0] last_pc;

  wb_stage #(.DATA_W(32), .RF_ADDR_W(5), .PC_W(32)) dut (
    .aclk(aclk), .areset(areset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_rd(ms_rd), .ms_we(ms_we), .ms_res_sel(ms_res_sel),
    .ms_ld_type(ms_ld_type), .ms_addr_lo(ms_addr_lo), .ms_alu_res(ms_alu_res),
    .ms_csr_rdata(ms_csr_rdata), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_pend_we(ws_pend_we), .ws_pend_rd(ws_pend_rd), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Load value from the architectural rules: shift the lane down, mask, extend.
  function automatic logic [31:0] ref_load(input int t, input int lo, input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (t)
      0:       return (b >= 32'd128) ? b - 32'd256 : b;
      1:       return (h >= 32'd32768) ? h - 32'd65536 : h;
      3:       return b;
      4:       return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input int sel, input logic [31:0] pc,
                                             input logic [31:0] alu, input logic [31:0] csr,
                                             input logic [31:0] ld);
    case (sel)
      1:       return ld;
      2:       return pc + 32'd4;
      3:       return csr;
      default: return alu;
    endcase
  endfunction

  task automatic scramble_ms();
    ms_pc        = $urandom;
    ms_rd        = 5'($urandom);
    ms_we        = 1'($urandom);
    ms_res_sel   = 2'($urandom);
    ms_ld_type   = 3'($urandom);
    ms_addr_lo   = 2'($urandom);
    ms_alu_res   = $urandom;
    ms_csr_rdata = $urandom;
  endtask

  // Present one bundle now, follow it to its commit, then idle for gap cycles.
  task automatic run_op(input string tag, input logic [31:0] pc, input int rd, input bit we,
                        input int sel, input int ldt, input int lo, input logic [31:0] alu,
                        input logic [31:0] csr, input logic [31:0] rdata,
                        input int rdelay, input int gap);
    logic [31:0] exp_d;
    logic [31:0] exp_we;
    exp_we = (we && rd != 0) ? 32'd1 : 32'd0;
    exp_d  = ref_result(sel, pc, alu, csr, ref_load(ldt, lo, rdata));
    ms_valid     = 1'b1;
    ms_pc        = pc;
    ms_rd        = 5'(rd);
    ms_we        = we;
    ms_res_sel   = 2'(sel);
    ms_ld_type   = 3'(ldt);
    ms_addr_lo   = 2'(lo);
    ms_alu_res   = alu;
    ms_csr_rdata = csr;
    chk({tag, " allowin_at_accept"}, 32'(ws_allowin), 32'd1);
    tick();
    ms_valid = 1'b0;
    scramble_ms();
    if (sel == 1) begin
      for (int i = 0; i <= rdelay; i++) begin
        chk({tag, " wait_allowin"}, 32'(ws_allowin), 32'd0);
        chk({tag, " wait_pend_we"}, 32'(ws_pend_we), exp_we);
        chk({tag, " wait_pend_rd"}, 32'(ws_pend_rd), 32'(rd));
        chk({tag, " wait_rf_we"}, 32'(rf_we), 32'd0);
        chk({tag, " wait_waddr_hold"}, 32'(rf_waddr), last_waddr);
        chk({tag, " wait_wdata_hold"}, rf_wdata, last_wdata);
        if (i < rdelay) tick();
      end
      data_rvalid = 1'b1;
      data_rdata  = rdata;
      tick();
      data_rvalid = 1'b0;
      data_rdata  = $urandom;
    end
    chk({tag, " rf_we"}, 32'(rf_we), exp_we);
    chk({tag, " dbg_rf_we"}, 32'(debug_wb_rf_we), exp_we * 32'hF);
    chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(rd));
    chk({tag, " dbg_wnum"}, 32'(debug_wb_rf_wnum), 32'(rd));
    chk({tag, " rf_wdata"}, rf_wdata, exp_d);
    chk({tag, " dbg_wdata"}, debug_wb_rf_wdata, exp_d);
    chk({tag, " dbg_pc"}, debug_wb_pc, pc);
    chk({tag, " commit_pend_we"}, 32'(ws_pend_we), 32'd0);
    last_waddr = 32'(rd);
    last_wdata = exp_d;
    last_pc    = pc;
    for (int i = 0; i < gap; i++) begin
      tick();
      chk({tag, " idle_rf_we"}, 32'(rf_we), 32'd0);
      chk({tag, " idle_dbg_we"}, 32'(debug_wb_rf_we), 32'd0);
      chk({tag, " idle_wdata_hold"}, rf_wdata, last_wdata);
      chk({tag, " idle_allowin"}, 32'(ws_allowin), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    int rd, sel, ldt, lo;
    bit we;
    areset      = 1'b1;
    ms_valid    = 1'b0;
    data_rvalid = 1'b0;
    data_rdata  = '0;
    scramble_ms();
    tick();
    tick();
    chk("reset allowin", 32'(ws_allowin), 32'd1);
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset rf_wdata", rf_wdata, 32'd0);
    chk("reset pend_we", 32'(ws_pend_we), 32'd0);
    chk("reset pend_rd", 32'(ws_pend_rd), 32'd0);
    chk("reset dbg_pc", debug_wb_pc, 32'd0);
    chk("reset dbg_we", 32'(debug_wb_rf_we), 32'd0);
    areset     = 1'b0;
    last_waddr = '0;
    last_wdata = '0;
    last_pc    = '0;

    run_op("t1_alu", 32'h1c000000, 4, 1, 0, 0, 0, 32'h12345678, 32'h0, 32'h0, 0, 1);
    run_op("t2_ldb", 32'h1c000004, 5, 1, 1, 0, 3, 32'h0, 32'h0, 32'h80FFFFFF, 2, 1);
    run_op("t2_ldbu", 32'h1c000008, 5, 1, 1, 3, 3, 32'h0, 32'h0, 32'h80FFFFFF, 2, 1);
    run_op("t3_ldh", 32'h1c00000c, 6, 1, 1, 1, 2, 32'h0, 32'h0, 32'h80017FFF, 0, 1);
    run_op("t3_ldhu", 32'h1c000010, 7, 1, 1, 4, 0, 32'h0, 32'h0, 32'h80017FFF, 1, 1);
    run_op("t3_ldw", 32'h1c000014, 8, 1, 1, 2, 0, 32'h0, 32'h0, 32'hCAFEF00D, 4, 1);

    for (int i = 1; i <= 5; i++)
      run_op("t4_b2b", 32'h1c000100 + 32'(4 * i), i, 1, 0, 0, 0, 32'hA0000000 + 32'(i),
             32'h0, 32'h0, 0, (i == 5) ? 1 : 0);

    run_op("t5_rd0", 32'h1c000200, 0, 1, 0, 0, 0, 32'h55AA55AA, 32'h0, 32'h0, 0, 1);
    run_op("t5_pc4wrap", 32'hFFFFFFFC, 9, 1, 2, 0, 0, 32'h11111111, 32'h0, 32'h0, 0, 1);
    run_op("t5_csr", 32'h1c000204, 10, 1, 3, 0, 0, 32'h11111111, 32'hDEADBEEF, 32'h0, 0, 1);
    run_op("t5_we0", 32'h1c000208, 11, 0, 0, 0, 0, 32'h22222222, 32'h0, 32'h0, 0, 1);

    // Reset while a load waits: the load is dropped and the late response ignored.
    ms_valid = 1'b1;
    ms_pc = 32'h1c000300; ms_rd = 5'd12; ms_we = 1'b1; ms_res_sel = 2'd1;
    ms_ld_type = 3'd2; ms_addr_lo = 2'd0;
    tick();
    ms_valid = 1'b0;
    chk("t6 in_wait_allowin", 32'(ws_allowin), 32'd0);
    chk("t6 in_wait_pend_we", 32'(ws_pend_we), 32'd1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("t6 post_reset_allowin", 32'(ws_allowin), 32'd1);
    chk("t6 post_reset_pend_we", 32'(ws_pend_we), 32'd0);
    data_rvalid = 1'b1;
    data_rdata  = 32'h99999999;
    tick();
    data_rvalid = 1'b0;
    chk("t6 late_rvalid_rf_we", 32'(rf_we), 32'd0);
    chk("t6 late_rvalid_allowin", 32'(ws_allowin), 32'd1);
    chk("t6 late_rvalid_pend_we", 32'(ws_pend_we), 32'd0);
    chk("t6 late_rvalid_wdata", rf_wdata, 32'd0);
    tick();
    chk("t6 settle_rf_we", 32'(rf_we), 32'd0);
    last_waddr = '0;
    last_wdata = '0;

    for (int n = 0; n < 300; n++) begin
      rd  = int'($urandom_range(0, 31));
      we  = ($urandom_range(0, 3) != 0);
      sel = int'($urandom_range(0, 3));
      ldt = int'($urandom_range(0, 4));
      lo  = int'($urandom_range(0, 3));
      if (ldt == 1 || ldt == 4) lo = lo & 2;
      run_op("rand", $urandom, rd, we, sel, ldt, lo, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 4)), (n == 299) ? 1 : int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
